// File: rtl/dor_bp_router_buf.sv
// Dimension-order (X then Y) mesh router slice: N/W input FIFOs,
// registered E/S/client outputs, fixed priority with W-over-N anti-starvation.
module dor_bp_router_buf #(
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int X          = 0,
    parameter int Y          = 0,
    parameter int D_W        = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] n_x,
    input  logic [Y_W-1:0] n_y,
    input  logic [D_W-1:0] n_d,
    input  logic           n_v,
    output logic           n_b,
    input  logic [X_W-1:0] w_x,
    input  logic [Y_W-1:0] w_y,
    input  logic [D_W-1:0] w_d,
    input  logic           w_v,
    output logic           w_b,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic [D_W-1:0] i_d,
    input  logic           i_v,
    output logic           i_ack,
    output logic [X_W-1:0] e_x,
    output logic [Y_W-1:0] e_y,
    output logic [D_W-1:0] e_d,
    output logic           e_v,
    input  logic           e_b,
    output logic [X_W-1:0] s_x,
    output logic [Y_W-1:0] s_y,
    output logic [D_W-1:0] s_d,
    output logic           s_v,
    input  logic           s_b,
    output logic [D_W-1:0] o_d,
    output logic           o_v,
    input  logic           client_b
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = X_W + Y_W + D_W;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [X_W-1:0] XA = X_W'(X);
    localparam logic [Y_W-1:0] YA = Y_W'(Y);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [PW-1:0] n_mem_q [FIFO_DEPTH];
    logic [PW-1:0] w_mem_q [FIFO_DEPTH];
    logic [AW-1:0] n_wp_q, n_rp_q, w_wp_q, w_rp_q;
    logic [CW-1:0] n_cnt_q, n_cnt_d, w_cnt_q, w_cnt_d;
    logic          n_wr, n_pop, n_ne, w_wr, w_pop, w_ne;
    logic [PW-1:0] n_head, w_head, p_pkt;
    logic [X_W-1:0] n_hx, w_hx;
    logic [Y_W-1:0] n_hy, w_hy;
    logic [D_W-1:0] n_hd, w_hd;

    assign n_b    = n_cnt_q == FULL;
    assign w_b    = w_cnt_q == FULL;
    assign n_wr   = n_v && !n_b;
    assign w_wr   = w_v && !w_b;
    assign n_ne   = n_cnt_q != '0;
    assign w_ne   = w_cnt_q != '0;
    assign n_head = n_mem_q[n_rp_q];
    assign w_head = w_mem_q[w_rp_q];
    assign p_pkt  = {i_x, i_y, i_d};
    assign n_hx   = n_head[PW-1 -: X_W];
    assign n_hy   = n_head[D_W +: Y_W];
    assign n_hd   = n_head[D_W-1:0];
    assign w_hx   = w_head[PW-1 -: X_W];
    assign w_hy   = w_head[D_W +: Y_W];
    assign w_hd   = w_head[D_W-1:0];

    // Route requests: local -> O, north always continues south,
    // W/PE turn south once the column matches, otherwise go east.
    logic n_me, w_me, p_me;
    logic n_rs, n_ro, w_rs, w_ro, w_re, p_rs, p_ro, p_re;

    assign n_me = n_hx == XA && n_hy == YA;
    assign w_me = w_hx == XA && w_hy == YA;
    assign p_me = i_x == XA && i_y == YA;
    assign n_ro = n_ne && n_me;
    assign n_rs = n_ne && !n_me;
    assign w_ro = w_ne && w_me;
    assign w_rs = w_ne && !w_me && w_hx == XA;
    assign w_re = w_ne && !w_me && w_hx != XA;
    assign p_ro = i_v && p_me;
    assign p_rs = i_v && !p_me && i_x == XA;
    assign p_re = i_v && !p_me && i_x != XA;

    logic e_v_q, s_v_q, o_v_q;
    logic [X_W-1:0] e_x_q, s_x_q;
    logic [Y_W-1:0] e_y_q, s_y_q;
    logic [D_W-1:0] e_d_q, s_d_q, o_d_q;
    logic [SW-1:0] starve_q, starve_d;
    logic e_ld, s_ld, o_ld, w_pri;
    logic e_gw, e_gp, s_gn, s_gw, s_gp, o_gn, o_gw, o_gp;

    assign e_ld  = !e_v_q || !e_b;
    assign s_ld  = !s_v_q || !s_b;
    assign o_ld  = !o_v_q || !client_b;
    assign w_pri = starve_q == SMAX;

    assign e_gw = e_ld && w_re;
    assign e_gp = e_ld && p_re && !w_re;
    assign s_gn = s_ld && n_rs && !(w_pri && w_rs);
    assign s_gw = s_ld && w_rs && (!n_rs || w_pri);
    assign s_gp = s_ld && p_rs && !n_rs && !w_rs;
    assign o_gn = o_ld && n_ro && !(w_pri && w_ro);
    assign o_gw = o_ld && w_ro && (!n_ro || w_pri);
    assign o_gp = o_ld && p_ro && !n_ro && !w_ro;

    assign n_pop = s_gn || o_gn;
    assign w_pop = e_gw || s_gw || o_gw;
    assign i_ack = rst_n && (e_gp || s_gp || o_gp);

    always_comb begin
        n_cnt_d = n_cnt_q + CW'(n_wr) - CW'(n_pop);
        w_cnt_d = w_cnt_q + CW'(w_wr) - CW'(w_pop);
    end

    // Starvation counts only real losses to N on a loadable output.
    always_comb begin
        starve_d = starve_q;
        if (!(w_rs || w_ro) || s_gw || o_gw) begin
            starve_d = '0;
        end else if ((s_gn && w_rs) || (o_gn && w_ro)) begin
            if (starve_q != SMAX) starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (n_wr) n_mem_q[n_wp_q] <= {n_x, n_y, n_d};
        if (w_wr) w_mem_q[w_wp_q] <= {w_x, w_y, w_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_wp_q   <= '0;
            n_rp_q   <= '0;
            n_cnt_q  <= '0;
            w_wp_q   <= '0;
            w_rp_q   <= '0;
            w_cnt_q  <= '0;
            starve_q <= '0;
        end else begin
            if (n_wr)  n_wp_q <= n_wp_q + AW'(1);
            if (n_pop) n_rp_q <= n_rp_q + AW'(1);
            if (w_wr)  w_wp_q <= w_wp_q + AW'(1);
            if (w_pop) w_rp_q <= w_rp_q + AW'(1);
            n_cnt_q  <= n_cnt_d;
            w_cnt_q  <= w_cnt_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_v_q <= 1'b0;
            e_x_q <= '0;
            e_y_q <= '0;
            e_d_q <= '0;
            s_v_q <= 1'b0;
            s_x_q <= '0;
            s_y_q <= '0;
            s_d_q <= '0;
            o_v_q <= 1'b0;
            o_d_q <= '0;
        end else begin
            if (e_ld) begin
                e_v_q <= e_gw || e_gp;
                if (e_gw)      {e_x_q, e_y_q, e_d_q} <= w_head;
                else if (e_gp) {e_x_q, e_y_q, e_d_q} <= p_pkt;
            end
            if (s_ld) begin
                s_v_q <= s_gn || s_gw || s_gp;
                if (s_gn)      {s_x_q, s_y_q, s_d_q} <= n_head;
                else if (s_gw) {s_x_q, s_y_q, s_d_q} <= w_head;
                else if (s_gp) {s_x_q, s_y_q, s_d_q} <= p_pkt;
            end
            if (o_ld) begin
                o_v_q <= o_gn || o_gw || o_gp;
                if (o_gn)      o_d_q <= n_hd;
                else if (o_gw) o_d_q <= w_hd;
                else if (o_gp) o_d_q <= i_d;
            end
        end
    end

    assign e_v = e_v_q;
    assign e_x = e_x_q;
    assign e_y = e_y_q;
    assign e_d = e_d_q;
    assign s_v = s_v_q;
    assign s_x = s_x_q;
    assign s_y = s_y_q;
    assign s_d = s_d_q;
    assign o_v = o_v_q;
    assign o_d = o_d_q;

endmodule

// File: tb/tb_dor_bp_router_buf.sv
// Randomized and directed bench for dor_bp_router_buf at (1,1), 2-bit
// addresses, 8-bit payload, depth-4 FIFOs, starvation limit 4.
module tb_dor_bp_router_buf;
    localparam int DEPTH = 4;
    localparam int SMAX  = 4;
    localparam int MX    = 1;
    localparam int MY    = 1;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic [7:0] d;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [1:0] n_x = '0, w_x = '0, i_x = '0;
    logic [1:0] n_y = '0, w_y = '0, i_y = '0;
    logic [7:0] n_d = '0, w_d = '0, i_d = '0;
    logic n_v = 1'b0, w_v = 1'b0, i_v = 1'b0;
    logic e_b = 1'b0, s_b = 1'b0, client_b = 1'b0;
    logic n_b, w_b, i_ack, e_v, s_v, o_v;
    logic [1:0] e_x, e_y, s_x, s_y;
    logic [7:0] e_d, s_d, o_d;

    always #5 clk = ~clk;

    dor_bp_router_buf #(
        .X_W(2), .Y_W(2), .X(MX), .Y(MY), .D_W(8),
        .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .n_x(n_x), .n_y(n_y), .n_d(n_d), .n_v(n_v), .n_b(n_b),
        .w_x(w_x), .w_y(w_y), .w_d(w_d), .w_v(w_v), .w_b(w_b),
        .i_x(i_x), .i_y(i_y), .i_d(i_d), .i_v(i_v), .i_ack(i_ack),
        .e_x(e_x), .e_y(e_y), .e_d(e_d), .e_v(e_v), .e_b(e_b),
        .s_x(s_x), .s_y(s_y), .s_d(s_d), .s_v(s_v), .s_b(s_b),
        .o_d(o_d), .o_v(o_v), .client_b(client_b)
    );

    // Reference model: queues for the FIFOs, plain records for the outputs.
    pkt_t nq[$];
    pkt_t wq[$];
    bit   mev, msv, mov;
    pkt_t me_p, ms_p;
    logic [7:0] mod;
    int   starve;
    bit   m_ack;
    bit   dut_ack;
    int   passes = 0;
    int   total = 0;
    logic [7:0] got[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // 0 = east, 1 = south, 2 = client
    function automatic int route(pkt_t p, bit from_n);
        if (p.x == MX && p.y == MY) return 2;
        if (from_n || p.x == MX) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        nq.delete();
        wq.delete();
        mev = 0; msv = 0; mov = 0;
        me_p = '0; ms_p = '0; mod = '0;
        starve = 0;
        m_ack = 0;
    endtask

    // One clock cycle: inputs are already applied at the preceding negedge.
    task automatic step();
        pkt_t ip, nh, wh, src;
        int nr, wr, pr;
        bit ld[3];
        int win[3];
        bit nfull, wfull, nwr, wwr;
        #1;
        ip = {i_x, i_y, i_d};
        nh = '0;
        wh = '0;
        nr = -1;
        wr = -1;
        if (nq.size() > 0) begin nh = nq[0]; nr = route(nh, 1); end
        if (wq.size() > 0) begin wh = wq[0]; wr = route(wh, 0); end
        pr = i_v ? route(ip, 0) : -1;
        ld[0] = !mev || !e_b;
        ld[1] = !msv || !s_b;
        ld[2] = !mov || !client_b;
        for (int o = 0; o < 3; o++) begin
            win[o] = -1;
            if (ld[o]) begin
                if (wr == o && starve >= SMAX) win[o] = 1;
                else if (nr == o) win[o] = 0;
                else if (wr == o) win[o] = 1;
                else if (pr == o) win[o] = 2;
            end
        end
        m_ack = win[0] == 2 || win[1] == 2 || win[2] == 2;
        nfull = nq.size() == DEPTH;
        wfull = wq.size() == DEPTH;
        dut_ack = i_ack;
        chk("i_ack", 32'(i_ack), 32'(m_ack));
        chk("n_b", 32'(n_b), 32'(nfull));
        chk("w_b", 32'(w_b), 32'(wfull));
        @(posedge clk);
        nwr = n_v && !nfull;
        wwr = w_v && !wfull;
        if (win[1] == 0 || win[2] == 0) void'(nq.pop_front());
        if (win[0] == 1 || win[1] == 1 || win[2] == 1) void'(wq.pop_front());
        if (nwr) nq.push_back({n_x, n_y, n_d});
        if (wwr) wq.push_back({w_x, w_y, w_d});
        for (int o = 0; o < 3; o++) begin
            src = (win[o] == 0) ? nh : (win[o] == 1) ? wh : ip;
            if (ld[o]) begin
                if (o == 0) begin mev = win[o] != -1; if (mev) me_p = src; end
                if (o == 1) begin msv = win[o] != -1; if (msv) ms_p = src; end
                if (o == 2) begin mov = win[o] != -1; if (mov) mod = src.d; end
            end
        end
        if (!(wr == 1 || wr == 2)) starve = 0;
        else if (win[wr] == 1) starve = 0;
        else if (win[wr] == 0) starve = (starve < SMAX) ? starve + 1 : SMAX;
        @(negedge clk);
        chk("east", 32'({e_v, e_x, e_y, e_d}), 32'({mev, me_p}));
        chk("south", 32'({s_v, s_x, s_y, s_d}), 32'({msv, ms_p}));
        chk("client", 32'({o_v, o_d}), 32'({mov, mod}));
    endtask

    task automatic idle_inputs();
        n_v = 0; w_v = 0; i_v = 0;
        e_b = 0; s_b = 0; client_b = 0;
    endtask

    // Asserts reset between edges and checks that it acts without a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valids", 32'({e_v, s_v, o_v}), 32'(0));
        chk("rst_bp", 32'({n_b, w_b, i_ack}), 32'(0));
        chk("rst_data", 32'({e_x, e_y, e_d, s_x, s_y, s_d}), 32'(0));
        chk("rst_o_d", 32'(o_d), 32'(0));
        model_clear();
        @(negedge clk);
        chk("rst_hold_ack", 32'(i_ack), 32'(0));
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp4[$];
        model_clear();
        #1;
        i_v = 1; i_x = 2'd1; i_y = 2'd1; i_d = 8'h33;
        do_reset();

        // Local delivery: two edges from presentation to o_v.
        n_v = 1; n_x = 2'd1; n_y = 2'd1; n_d = 8'hA5;
        step();
        n_v = 0;
        chk("t1_o_early", 32'(o_v), 32'(0));
        step();
        chk("t1_o_v", 32'(o_v), 32'(1));
        chk("t1_o_d", 32'(o_d), 32'hA5);
        chk("t1_s_v", 32'(s_v), 32'(0));
        repeat (2) step();

        // W beats PE on east; PE gets the following slot.
        w_v = 1; w_x = 2'd2; w_y = 2'd0; w_d = 8'h11;
        step();
        w_v = 0;
        i_v = 1; i_x = 2'd3; i_y = 2'd0; i_d = 8'h22;
        step();
        chk("t2_ack_wait", 32'(dut_ack), 32'(0));
        chk("t2_first", 32'({e_v, e_d}), 32'({1'b1, 8'h11}));
        step();
        chk("t2_ack", 32'(dut_ack), 32'(1));
        i_v = 0;
        chk("t2_second", 32'({e_v, e_d}), 32'({1'b1, 8'h22}));
        repeat (2) step();

        // South blocked: register holds one, FIFO takes four, fifth refused.
        s_b = 1;
        n_v = 1; n_x = 2'd1; n_y = 2'd3; n_d = 8'h80;
        step();
        n_v = 0;
        step();
        for (int k = 1; k <= 5; k++) begin
            n_v = 1; n_x = 2'd1; n_y = 2'd3; n_d = 8'(k);
            if (k == 5) chk("t3_full", 32'(n_b), 32'(1));
            step();
        end
        n_v = 0;
        chk("t3_still_full", 32'(n_b), 32'(1));
        chk("t3_hold", 32'({s_v, s_d}), 32'({1'b1, 8'h80}));
        s_b = 0;
        got.delete();
        repeat (8) begin
            step();
            if (s_v) got.push_back(s_d);
        end
        chk("t3_count", 32'(got.size()), 32'(4));
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk("t3_order", 32'(got[k]), 32'(k + 1));

        // Starvation: W loses four times to streaming N, then wins once.
        got.delete();
        for (int k = 1; k <= 12; k++) begin
            n_v = 1; n_x = 2'd1; n_y = 2'd3; n_d = 8'(k);
            w_v = (k == 4); w_x = 2'd1; w_y = 2'd2; w_d = 8'hEE;
            step();
            if (s_v) got.push_back(s_d);
        end
        n_v = 0; w_v = 0;
        repeat (6) begin
            step();
            if (s_v) got.push_back(s_d);
        end
        exp4 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'hEE,
                 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
        chk("t4_count", 32'(got.size()), 32'(13));
        for (int k = 0; k < 13 && k < got.size(); k++)
            chk("t4_order", 32'(got[k]), 32'(exp4[k]));

        // East held under backpressure.
        e_b = 1;
        w_v = 1; w_x = 2'd2; w_y = 2'd0; w_d = 8'h5A;
        step();
        w_v = 1; w_x = 2'd3; w_y = 2'd1; w_d = 8'h6B;
        step();
        w_v = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t5_hold", 32'({e_v, e_x, e_y, e_d}),
                32'({1'b1, 2'd2, 2'd0, 8'h5A}));
        end
        e_b = 0;
        step();
        chk("t5_next", 32'({e_v, e_x, e_y, e_d}), 32'({1'b1, 2'd3, 2'd1, 8'h6B}));
        repeat (2) step();

        // Reset with traffic in flight.
        e_b = 1; s_b = 1; client_b = 1;
        for (int k = 0; k < 12; k++) begin
            n_v = 1; n_x = 2'($urandom_range(0, 3)); n_y = 2'($urandom_range(0, 3));
            n_d = 8'($urandom);
            w_v = 1; w_x = 2'($urandom_range(0, 3)); w_y = 2'($urandom_range(0, 3));
            w_d = 8'($urandom);
            step();
        end
        n_v = 0; w_v = 0;
        i_v = 1; i_x = 2'd0; i_y = 2'd0; i_d = 8'h77;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t6_no_stale", 32'({e_v, s_v, o_v}), 32'(0));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) do_reset();
            n_v = ($urandom_range(0, 1) == 1);
            n_x = 2'($urandom_range(0, 3)); n_y = 2'($urandom_range(0, 3));
            n_d = 8'($urandom);
            w_v = ($urandom_range(0, 1) == 1);
            w_x = 2'($urandom_range(0, 3)); w_y = 2'($urandom_range(0, 3));
            w_d = 8'($urandom);
            if (!i_v || m_ack) begin
                i_v = ($urandom_range(0, 2) == 0);
                i_x = 2'($urandom_range(0, 3)); i_y = 2'($urandom_range(0, 3));
                i_d = 8'($urandom);
            end
            e_b = ($urandom_range(0, 3) == 0);
            s_b = ($urandom_range(0, 3) == 0);
            client_b = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
